// File: rtl/l2_line_responder.sv
// L2 line responder: round-robin accepts one I/D line fill at a time and returns
// an address-synthesized 512-bit line after a fixed latency.
module l2_line_responder #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_req,
   input  logic [31:0]        i_add_in,
   output logic               i_ready,
   input  logic               d_req,
   input  logic [31:0]        d_add_in,
   output logic               d_ready,
   output logic               i_rsp_valid,
   output logic [511:0]       i_data_out,
   output logic               d_rsp_valid,
   output logic [511:0]       d_data_out,
   output logic [31:0]        rsp_add,
   output logic               busy,
   output logic [CNT_W-1:0]   served_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   logic [1:0]       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             port_q, port_d;
   logic             pri_q, pri_d;
   logic [31:0]      line_add_q, line_add_d;
   logic [31:0]      rsp_add_q, rsp_add_d;
   logic [511:0]     i_data_q, i_data_d;
   logic [511:0]     d_data_q, d_data_d;
   logic [CNT_W-1:0] served_q, served_d;

   logic             grant_i, grant_d;
   logic [511:0]     line_data;
   logic             unused_low_bits;

   assign unused_low_bits = ^{i_add_in[5:0], d_add_in[5:0]};

   // Round-robin only matters when both ports ask in the same cycle.
   assign grant_i = (state_q == S_IDLE) && i_req && (!d_req || (pri_q == PORT_I));
   assign grant_d = (state_q == S_IDLE) && d_req && (!i_req || (pri_q == PORT_D));

   always_comb begin
      for (int k = 0; k < 16; k++) begin
         line_data[32*k +: 32] = {line_add_q[31:6], 4'(k), 2'b00};
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a hold default first, so no path through
      // the case statement leaves one unassigned and infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      port_d     = port_q;
      pri_d      = pri_q;
      line_add_d = line_add_q;
      rsp_add_d  = rsp_add_q;
      i_data_d   = i_data_q;
      d_data_d   = d_data_q;
      served_d   = served_q;

      case (state_q)
         S_IDLE: begin
            if (grant_i || grant_d) begin
               port_d     = grant_d ? PORT_D : PORT_I;
               pri_d      = grant_d ? PORT_I : PORT_D;
               line_add_d = grant_d ? {d_add_in[31:6], 6'b0} : {i_add_in[31:6], 6'b0};
               cnt_d      = CNT_INIT;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d   = S_RESP;
               rsp_add_d = line_add_q;
               if (port_q == PORT_I) begin
                  i_data_d = line_data;
               end else begin
                  d_data_d = line_data;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (!(&served_q)) begin
               served_d = served_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values; the wide data registers are reset too, since the caches
   // rely on all-zero line buses coming out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         port_q     <= PORT_I;
         pri_q      <= PORT_I;
         line_add_q <= '0;
         rsp_add_q  <= '0;
         i_data_q   <= '0;
         d_data_q   <= '0;
         served_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         port_q     <= port_d;
         pri_q      <= pri_d;
         line_add_q <= line_add_d;
         rsp_add_q  <= rsp_add_d;
         i_data_q   <= i_data_d;
         d_data_q   <= d_data_d;
         served_q   <= served_d;
      end
   end

   assign i_ready     = grant_i;
   assign d_ready     = grant_d;
   assign i_rsp_valid = (state_q == S_RESP) && (port_q == PORT_I);
   assign d_rsp_valid = (state_q == S_RESP) && (port_q == PORT_D);
   assign i_data_out  = i_data_q;
   assign d_data_out  = d_data_q;
   assign rsp_add     = rsp_add_q;
   assign busy        = (state_q != S_IDLE);
   assign served_cnt  = served_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Self-checking bench for l2_line_responder: a LATENCY=4 instance for the main
// behaviour and a LATENCY=1, CNT_W=2 instance for back-to-back and saturation.
module tb_l2_line_responder;

   logic clk;
   logic rst_n;

   // LATENCY=4, CNT_W=16 instance
   logic         i_req4, d_req4;
   logic [31:0]  i_add4, d_add4;
   logic         i_ready4, d_ready4, i_valid4, d_valid4, busy4;
   logic [511:0] i_data4, d_data4;
   logic [31:0]  rsp_add4;
   logic [15:0]  served4;

   // LATENCY=1, CNT_W=2 instance
   logic         i_req1, d_req1;
   logic [31:0]  i_add1, d_add1;
   logic         i_ready1, d_ready1, i_valid1, d_valid1, busy1;
   logic [511:0] i_data1, d_data1;
   logic [31:0]  rsp_add1;
   logic [1:0]   served1;

   int checks = 0;
   int errors = 0;
   int exp_served4 = 0;

   l2_line_responder #(.LATENCY(4), .CNT_W(16)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req4), .i_add_in(i_add4), .i_ready(i_ready4),
      .d_req(d_req4), .d_add_in(d_add4), .d_ready(d_ready4),
      .i_rsp_valid(i_valid4), .i_data_out(i_data4),
      .d_rsp_valid(d_valid4), .d_data_out(d_data4),
      .rsp_add(rsp_add4), .busy(busy4), .served_cnt(served4)
   );

   l2_line_responder #(.LATENCY(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req1), .i_add_in(i_add1), .i_ready(i_ready1),
      .d_req(d_req1), .d_add_in(d_add1), .d_ready(d_ready1),
      .i_rsp_valid(i_valid1), .i_data_out(i_data1),
      .d_rsp_valid(d_valid1), .d_data_out(d_data1),
      .rsp_add(rsp_add1), .busy(busy1), .served_cnt(served1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          port;
      logic [31:0] addr;
      logic [31:0] e_add;
      logic [31:0] e_w0;
      logic [31:0] e_w7;
      logic [31:0] e_w15;
      string       tag;
   } vec_t;

   // One request on the LATENCY=4 instance, checked end to end.
   task automatic do_req4(input vec_t v);
      logic [511:0] other_snap;
      logic [511:0] dat;
      bit got;
      int k;
      @(negedge clk);
      if (v.port) begin d_req4 = 1'b1; d_add4 = v.addr; end
      else        begin i_req4 = 1'b1; i_add4 = v.addr; end
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         #1;
         if (v.port ? d_ready4 : i_ready4) got = 1'b1;
         else @(negedge clk);
      end
      check({v.tag, "_grant"}, 64'(got), 64'(1));
      check({v.tag, "_other_ready"}, 64'(v.port ? i_ready4 : d_ready4), 64'(0));
      other_snap = v.port ? i_data4 : d_data4;
      @(posedge clk);
      #1;
      i_req4 = 1'b0;
      d_req4 = 1'b0;
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) check({v.tag, "_busy"}, 64'(busy4), 64'(1));
         if (v.port ? d_valid4 : i_valid4) begin
            k = c;
            break;
         end
      end
      check({v.tag, "_latency"}, 64'(k), 64'(5));
      dat = v.port ? d_data4 : i_data4;
      check({v.tag, "_rsp_add"}, 64'(rsp_add4), 64'(v.e_add));
      check({v.tag, "_w0"},  64'(dat[0   +: 32]), 64'(v.e_w0));
      check({v.tag, "_w7"},  64'(dat[224 +: 32]), 64'(v.e_w7));
      check({v.tag, "_w15"}, 64'(dat[480 +: 32]), 64'(v.e_w15));
      check({v.tag, "_other_valid"}, 64'(v.port ? i_valid4 : d_valid4), 64'(0));
      check({v.tag, "_other_data_held"},
            64'((v.port ? i_data4 : d_data4) == other_snap), 64'(1));
      @(negedge clk);
      check({v.tag, "_pulse_width"}, 64'(v.port ? d_valid4 : i_valid4), 64'(0));
      check({v.tag, "_idle"}, 64'(busy4), 64'(0));
      exp_served4++;
      check({v.tag, "_served"}, 64'(served4), 64'(exp_served4));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      exp_served4 = 0;
   endtask

   initial begin
      vec_t vecs[5];
      logic [511:0] i_snap;
      logic [2:0]   order;
      int           n, k, bad, stale, nresp, last_grant, grants;
      bit           dseen, pend;
      logic [1:0]   exp_sat[5];

      vecs[0] = '{1'b0, 32'h0000_1234, 32'h0000_1200, 32'h0000_1200, 32'h0000_121C, 32'h0000_123C, "i_1234"};
      vecs[1] = '{1'b1, 32'hFFFF_FFC0, 32'hFFFF_FFC0, 32'hFFFF_FFC0, 32'hFFFF_FFDC, 32'hFFFF_FFFC, "d_ffc0"};
      vecs[2] = '{1'b1, 32'h8000_003F, 32'h8000_0000, 32'h8000_0000, 32'h8000_001C, 32'h8000_003C, "d_803f"};
      vecs[3] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEC0, 32'hDEAD_BEC0, 32'hDEAD_BEDC, 32'hDEAD_BEFC, "i_beef"};
      vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_001C, 32'h0000_003C, "i_zero"};
      exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      rst_n  = 1'b0;
      i_req4 = 1'b0; d_req4 = 1'b0; i_add4 = '0; d_add4 = '0;
      i_req1 = 1'b0; d_req1 = 1'b0; i_add1 = '0; d_add1 = '0;
      #12;
      check("rst_busy", 64'(busy4), 64'(0));
      check("rst_valids", 64'({i_valid4, d_valid4}), 64'(0));
      check("rst_rsp_add", 64'(rsp_add4), 64'(0));
      check("rst_data_zero", 64'((|i_data4) | (|d_data4)), 64'(0));
      check("rst_served", 64'(served4), 64'(0));
      check("rst_served_l1", 64'(served1), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) do_req4(vecs[i]);

      // d_req raised while an I request is in flight
      @(negedge clk);
      i_req4 = 1'b1;
      i_add4 = 32'h0000_4000;
      #1;
      check("busy_i_grant", 64'(i_ready4), 64'(1));
      @(posedge clk);
      #1;
      i_req4 = 1'b0;
      d_req4 = 1'b1;
      d_add4 = 32'h0000_5678;
      bad = 0;
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         #1;
         if (busy4) begin
            if (d_ready4) bad++;
         end else begin
            k = c;
            break;
         end
      end
      check("ready_while_busy", 64'(bad), 64'(0));
      check("first_idle_cycle", 64'(k), 64'(6));
      check("d_grant_in_idle", 64'(d_ready4), 64'(1));
      @(posedge clk);
      #1;
      d_req4 = 1'b0;
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (d_valid4) begin k = c; break; end
      end
      check("busy_d_latency", 64'(k), 64'(5));
      check("busy_d_rsp_add", 64'(rsp_add4), 64'(32'h0000_5640));
      @(negedge clk);
      exp_served4 += 2;
      check("busy_served", 64'(served4), 64'(exp_served4));

      // Both ports held from reset: I, D, I
      do_reset();
      i_req4 = 1'b1; i_add4 = 32'h0000_1234;
      d_req4 = 1'b1; d_add4 = 32'hFFFF_FFC0;
      n = 0; bad = 0; dseen = 1'b0; order = '0; i_snap = '0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (i_ready4 && d_ready4) bad++;
         if (i_ready4) begin order = {order[1:0], 1'b0}; n++; end
         if (d_ready4) begin order = {order[1:0], 1'b1}; n++; end
         if (i_valid4) i_snap = i_data4;
         if (d_valid4) begin
            dseen = 1'b1;
            check("sim_d_w15", 64'(d_data4[480 +: 32]), 64'(32'hFFFF_FFFC));
            check("sim_i_data_held", 64'(i_data4 == i_snap), 64'(1));
         end
         if (n >= 3) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      i_req4 = 1'b0;
      d_req4 = 1'b0;
      check("sim_grant_count", 64'(n), 64'(3));
      check("sim_grant_order", 64'(order), 64'(3'b010));
      check("sim_ready_exclusive", 64'(bad), 64'(0));
      check("sim_d_rsp_seen", 64'(dseen), 64'(1));
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (i_valid4) begin k = c; break; end
      end
      check("sim_third_latency", 64'(k), 64'(5));
      @(negedge clk);
      check("sim_served", 64'(served4), 64'(3));

      // Reset two cycles after acceptance
      @(negedge clk);
      i_req4 = 1'b1;
      i_add4 = 32'h0000_ABCD;
      #1;
      check("mid_grant", 64'(i_ready4), 64'(1));
      @(posedge clk);
      #1;
      i_req4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("mid_busy_before", 64'(busy4), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mid_async_busy", 64'(busy4), 64'(0));
      check("mid_async_valids", 64'({i_valid4, d_valid4}), 64'(0));
      check("mid_async_rsp_add", 64'(rsp_add4), 64'(0));
      check("mid_async_data", 64'((|i_data4) | (|d_data4)), 64'(0));
      check("mid_async_served", 64'(served4), 64'(0));
      #10;
      @(negedge clk);
      rst_n = 1'b1;
      exp_served4 = 0;
      stale = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (i_valid4 || d_valid4 || busy4) stale++;
      end
      check("mid_no_stale", 64'(stale), 64'(0));
      do_req4('{1'b0, 32'h0000_0044, 32'h0000_0040, 32'h0000_0040, 32'h0000_005C, 32'h0000_007C, "post_rst"});

      // LATENCY=1 back-to-back with 2-bit saturating counter
      @(negedge clk);
      i_req1 = 1'b1;
      i_add1 = 32'h1000_0080;
      nresp = 0; pend = 1'b0; last_grant = -1; grants = 0; bad = 0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (pend) begin
            check("l1_pulse_width", 64'(i_valid1), 64'(0));
            check("l1_served", 64'(served1), 64'(exp_sat[nresp-1]));
            pend = 1'b0;
            if (nresp == 5) break;
         end
         if (i_valid1) begin nresp++; pend = 1'b1; end
         if (i_ready1) begin
            if (last_grant >= 0 && (c - last_grant) != 3) bad++;
            last_grant = c;
            grants++;
         end
         @(negedge clk);
      end
      i_req1 = 1'b0;
      check("l1_resp_count", 64'(nresp), 64'(5));
      check("l1_grant_count", 64'(grants), 64'(5));
      check("l1_grant_spacing", 64'(bad), 64'(0));
      check("l1_rsp_add", 64'(rsp_add1), 64'(32'h1000_0080));
      check("l1_d_quiet", 64'({d_valid1, |d_data1}), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
